byte_frame_receiver: RTL

- Consumer end of the 8-bit `data_out` byte stream produced by the team's test/source modules.
- Accepts bytes over a valid/ready handshake and delineates frames (sync, length, payload, checksum).
- Forwards payload bytes through a registered output stage.
- Reports per-frame completion and error status, and keeps saturating frame/error counters.

---
 rtl/byte_frame_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/byte_frame_receiver.sv
// Frame receiver for the 8-bit byte stream: sync, length, payload, XOR checksum.
// Payload bytes leave through a registered valid/ready stage; status is pulsed and counted.
module byte_frame_receiver #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int                    MAX_LEN    = 64,
    parameter int                    TIMEOUT    = 255,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int                    TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_L    = DATA_WIDTH'(MAX_LEN);

    localparam logic [1:0] CODE_CSUM   = 2'b01;
    localparam logic [1:0] CODE_BADLEN = 2'b10;
    localparam logic [1:0] CODE_TMO    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] csum;
    logic [TW-1:0]         tmo_cnt;

    logic                  accept;
    logic                  tmo_hit;
    logic                  load_out;
    logic                  done_set;
    logic                  err_set;
    logic [1:0]            code_set;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake and status decode
    always_comb begin
        state_nxt  = state;
        data_ready = 1'b1;
        load_out   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        code_set   = 2'b00;

        if (state == S_PAYLOAD) begin
            data_ready = !out_valid || out_ready;
        end

        accept  = data_valid && data_ready;
        // An accept in the cycle the idle counter would expire takes priority.
        tmo_hit = (state != S_IDLE) && !accept && (tmo_cnt == TMO_LAST);

        case (state)
            S_IDLE: begin
                if (accept && (data_in == SYNC_BYTE)) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (data_in > MAX_L) begin
                        err_set   = 1'b1;
                        code_set  = CODE_BADLEN;
                        state_nxt = S_IDLE;
                    end else if (data_in == '0) begin
                        state_nxt = S_CHK;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    load_out = 1'b1;
                    if (remaining == DATA_WIDTH'(1)) begin
                        state_nxt = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (data_in == csum) begin
                        done_set = 1'b1;
                    end else begin
                        err_set  = 1'b1;
                        code_set = CODE_CSUM;
                    end
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (tmo_hit) begin
            err_set   = 1'b1;
            code_set  = CODE_TMO;
            state_nxt = S_IDLE;
        end
    end

    // Frame bookkeeping: length, running checksum, idle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            csum      <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (state == S_LEN && accept) begin
                remaining <= data_in;
                csum      <= data_in;
            end else if (load_out) begin
                remaining <= remaining - 1'b1;
                csum      <= csum ^ data_in;
            end

            if (accept || (state_nxt != state) || (state == S_IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Registered payload output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_data  <= data_in;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status pulses and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'b00;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= done_set;
            frame_err  <= err_set;
            if (err_set) begin
                err_code <= code_set;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
            if (done_set && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
